// File: rtl/mem_config_queue.sv
// mem_config_queue: register-programmed buffer-descriptor queues.
// Each stream owns four config registers (VADDR, SIZE, STATUS, DONE_COUNT)
// and a FIFO of {vaddr,size} descriptors presented on a valid/ready port.

// One stream: staging vaddr, descriptor FIFO, sticky flags, pop counter.
module mem_config_stream #(
  parameter int QUEUE_DEPTH = 4,
  parameter int VADDR_BITS  = 48,
  parameter int SIZE_BITS   = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [1:0]            wr_sel,
  input  logic [63:0]           wr_data,
  input  logic                  ready,
  output logic                  valid,
  output logic [VADDR_BITS-1:0] head_vaddr,
  output logic [SIZE_BITS-1:0]  head_size,
  output logic [VADDR_BITS-1:0] staging,
  output logic [15:0]           occupancy,
  output logic                  ovf,
  output logic                  zsz,
  output logic [31:0]           done_count
);
  localparam int AW = $clog2(QUEUE_DEPTH);
  localparam int CW = AW + 1;

  logic [VADDR_BITS-1:0] q_vaddr [QUEUE_DEPTH];
  logic [SIZE_BITS-1:0]  q_size  [QUEUE_DEPTH];
  logic [AW-1:0]         rd_ptr, wr_ptr;
  logic [CW-1:0]         count;
  logic [SIZE_BITS-1:0]  wr_size;
  logic                  size_sel, stat_sel, done_sel, full, zero, push, pop;
  logic                  unused_data;

  assign wr_size     = wr_data[SIZE_BITS-1:0];
  assign size_sel    = wr_en && (wr_sel == 2'd1);
  assign stat_sel    = wr_en && (wr_sel == 2'd2);
  assign done_sel    = wr_en && (wr_sel == 2'd3);
  assign full        = (count == CW'(QUEUE_DEPTH));
  assign zero        = (wr_size == '0);
  // Full is judged on the pre-pop occupancy, so a same-cycle pop never
  // makes room for a write that arrived while full.
  assign push        = size_sel && !zero && !full;
  assign valid       = (count != '0);
  assign pop         = valid && ready;
  assign head_vaddr  = valid ? q_vaddr[rd_ptr] : '0;
  assign head_size   = valid ? q_size[rd_ptr]  : '0;
  assign occupancy   = 16'(count);
  assign unused_data = ^wr_data;

  // Descriptor storage; contents are only observed through the valid gate.
  always_ff @(posedge clk) begin
    if (push) begin
      q_vaddr[wr_ptr] <= staging;
      q_size[wr_ptr]  <= wr_size;
    end
  end

  // Pointers, occupancy, staging, sticky flags and the pop counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      staging    <= '0;
      ovf        <= 1'b0;
      zsz        <= 1'b0;
      done_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
      if (wr_en && wr_sel == 2'd0) staging <= wr_data[VADDR_BITS-1:0];
      if (size_sel && zero)              zsz <= 1'b1;
      else if (stat_sel && wr_data[33])  zsz <= 1'b0;
      if (size_sel && !zero && full)     ovf <= 1'b1;
      else if (stat_sel && wr_data[32])  ovf <= 1'b0;
      if (done_sel)  done_count <= '0;
      else if (pop)  done_count <= done_count + 32'd1;
    end
  end
endmodule

// Top: address decode, per-stream instances, registered read port.
module mem_config_queue #(
  parameter int NUM_STREAMS = 1,
  parameter int QUEUE_DEPTH = 4,
  parameter int REG_BASE    = 0,
  parameter int VADDR_BITS  = 48,
  parameter int SIZE_BITS   = 32
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              conf_wr_valid,
  input  logic [15:0]                       conf_wr_addr,
  input  logic [63:0]                       conf_wr_data,
  input  logic                              conf_rd_valid,
  input  logic [15:0]                       conf_rd_addr,
  output logic                              conf_rd_resp,
  output logic [63:0]                       conf_rd_data,
  output logic [NUM_STREAMS-1:0]            buf_valid,
  input  logic [NUM_STREAMS-1:0]            buf_ready,
  output logic [NUM_STREAMS*VADDR_BITS-1:0] buf_vaddr,
  output logic [NUM_STREAMS*SIZE_BITS-1:0]  buf_size
);
  logic [NUM_STREAMS-1:0][VADDR_BITS-1:0] head_vaddr, staging;
  logic [NUM_STREAMS-1:0][SIZE_BITS-1:0]  head_size;
  logic [NUM_STREAMS-1:0][15:0]           occ;
  logic [NUM_STREAMS-1:0][31:0]           done;
  logic [NUM_STREAMS-1:0]                 ovf, zsz;
  logic [16:0] wr_off, rd_off;
  logic        wr_hit, rd_hit, unused_off;
  logic [63:0] rd_mux;

  // Offsets go negative (bit 16 set) below the window base.
  assign wr_off = {1'b0, conf_wr_addr} - 17'(REG_BASE);
  assign rd_off = {1'b0, conf_rd_addr} - 17'(REG_BASE);
  assign wr_hit = conf_wr_valid && !wr_off[16] && (wr_off < 17'(4*NUM_STREAMS));
  assign rd_hit = conf_rd_valid && !rd_off[16] && (rd_off < 17'(4*NUM_STREAMS));
  assign unused_off = ^{wr_off[15:6], rd_off[15:6]};
  assign buf_vaddr  = head_vaddr;
  assign buf_size   = head_size;

  for (genvar i = 0; i < NUM_STREAMS; i++) begin : g_stream
    mem_config_stream #(
      .QUEUE_DEPTH(QUEUE_DEPTH), .VADDR_BITS(VADDR_BITS), .SIZE_BITS(SIZE_BITS)
    ) u_stream (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr_en      (wr_hit && (wr_off[5:2] == 4'(i))),
      .wr_sel     (wr_off[1:0]),
      .wr_data    (conf_wr_data),
      .ready      (buf_ready[i]),
      .valid      (buf_valid[i]),
      .head_vaddr (head_vaddr[i]),
      .head_size  (head_size[i]),
      .staging    (staging[i]),
      .occupancy  (occ[i]),
      .ovf        (ovf[i]),
      .zsz        (zsz[i]),
      .done_count (done[i])
    );
  end

  // Select the addressed register from the pre-edge state of every stream.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_STREAMS; i++) begin
      if (rd_off[5:2] == 4'(i)) begin
        case (rd_off[1:0])
          2'd0:    rd_mux = 64'(staging[i]);
          2'd1:    rd_mux = 64'(head_size[i]);
          2'd2:    rd_mux = {30'b0, zsz[i], ovf[i], 16'b0, occ[i]};
          default: rd_mux = {32'b0, done[i]};
        endcase
      end
    end
  end

  // Read response one cycle after the request; out-of-window reads are silent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conf_rd_resp <= 1'b0;
      conf_rd_data <= '0;
    end else begin
      conf_rd_resp <= rd_hit;
      if (rd_hit) conf_rd_data <= rd_mux;
    end
  end
endmodule

// File: doc/mem_config_queue.md
MEM_CONFIG_QUEUE -- requirements
Module: MemConfigQueue

Interface
REQ-001 SHALL have parameter NUM_STREAMS, default 1: number of independent buffer-descriptor streams (1..16).
REQ-002 SHALL have parameter QUEUE_DEPTH, default 4: descriptors held per stream (power of two, 2..64).
REQ-003 SHALL have parameter REG_BASE, default 0: first config register index owned by this block.
REQ-004 SHALL have parameter VADDR_BITS, default 48: virtual-address width.
REQ-005 SHALL have parameter SIZE_BITS, default 32: allocation-size width.
REQ-006 SHALL have port clk, input, 1: single clock; all logic is rising-edge.
REQ-007 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-008 SHALL have port conf_wr_valid, input, 1: config write strobe, one write per cycle.
REQ-009 SHALL have port conf_wr_addr, input, 16: config register index.
REQ-010 SHALL have port conf_wr_data, input, 64: write data.
REQ-011 SHALL have port conf_rd_valid, input, 1: config read request.
REQ-012 SHALL have port conf_rd_addr, input, 16: read register index.
REQ-013 SHALL have port conf_rd_resp, output, 1: read response valid.
REQ-014 SHALL have port conf_rd_data, output, 64: read response data.
REQ-015 SHALL have port buf_valid, output, NUM_STREAMS: descriptor valid per stream.
REQ-016 SHALL have port buf_ready, input, NUM_STREAMS: descriptor consumed per stream.
REQ-017 SHALL have port buf_vaddr, output, NUM_STREAMS*VADDR_BITS: head descriptor address, stream I at slice I.
REQ-018 SHALL have port buf_size, output, NUM_STREAMS*SIZE_BITS: head descriptor size, stream I at slice I.

Function
REQ-019 SHALL map stream I to registers R=REG_BASE+4*I: R+0 VADDR, R+1 SIZE, R+2 STATUS, R+3 DONE_COUNT; writes/reads outside the window SHALL be ignored, with no read response.
REQ-020 Write to VADDR SHALL load the per-stream staging register with wr_data[VADDR_BITS-1:0]; it SHALL not enqueue.
REQ-021 Write to SIZE with nonzero wr_data[SIZE_BITS-1:0] and queue not full SHALL enqueue {staging vaddr, size} in the same edge; staging vaddr SHALL be retained.
REQ-022 Write to SIZE while queue full SHALL be dropped and set sticky OVERFLOW; write of size 0 SHALL be dropped and set sticky ZERO_SIZE.
REQ-023 Per stream queue SHALL be FIFO order; buf_valid=1 iff occupancy>0; buf_vaddr/buf_size SHALL show the head entry, stable while buf_valid&&!buf_ready.
REQ-024 Handshake: pop when buf_valid&&buf_ready; buf_ready with buf_valid=0 SHALL have no effect.
REQ-025 An enqueue written at edge N SHALL give buf_valid=1 from cycle N+1 (one-cycle latency, no bypass).
REQ-026 Simultaneous enqueue and pop on the same stream SHALL leave occupancy unchanged; enqueue while full and popping in the same cycle SHALL still be dropped (full evaluated before pop).
REQ-027 Read/write pointers SHALL wrap modulo QUEUE_DEPTH; occupancy SHALL range 0..QUEUE_DEPTH without aliasing.
REQ-028 STATUS read SHALL return {bit 33 ZERO_SIZE, bit 32 OVERFLOW, bits 15:0 occupancy}; write to STATUS SHALL clear each flag whose data bit (32/33) is 1.
REQ-029 DONE_COUNT SHALL be a 32-bit per-stream count of pops, wrapping 0xFFFFFFFF->0; write to DONE_COUNT SHALL clear it (a pop in the same cycle yields 0).
REQ-030 Reads SHALL respond exactly one cycle after conf_rd_valid, reflecting state before that request edge; VADDR and SIZE reads SHALL return staging vaddr and head size (0 if empty).
REQ-031 Streams SHALL be fully independent; a config write touches at most one stream.

Reset
REQ-032 While rst_n=0: all queues empty, buf_valid=0, buf_vaddr=0, buf_size=0, staging=0, flags=0, DONE_COUNT=0, conf_rd_resp=0, conf_rd_data=0.
REQ-033 Reset asserted mid-operation SHALL discard all queued descriptors immediately; first enqueue is accepted on the first edge after deassertion.

Verification
REQ-034 NUM_STREAMS=2, QUEUE_DEPTH=4: write VADDR(s1)=0x1000, SIZE(s1)=0x40 -> next cycle buf_valid[1]=1, vaddr 0x1000, size 0x40; buf_valid[0]=0.
REQ-035 Five SIZE writes to s0 with ready=0 -> STATUS occupancy 4, OVERFLOW=1; drain with ready=1 -> sizes in order, fifth absent, DONE_COUNT=4.
REQ-036 Queue holds 4 (full), SIZE write and buf_ready=1 same cycle -> write dropped, occupancy 3, OVERFLOW=1.
REQ-037 Occupancy 2, enqueue and pop same cycle -> occupancy stays 2, order preserved; SIZE=0 write -> ZERO_SIZE=1, STATUS write 0x3_0000_0000 clears both flags.
REQ-038 Fill 3 descriptors, pulse rst_n low mid-drain -> buf_valid=0 asynchronously, STATUS reads 0 after release.
